// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-read-port register file.
package regfile_pkg;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_e;

   localparam int unsigned RF_XLEN     = 32;
   localparam int unsigned RF_NREGS    = 32;
   localparam int unsigned RF_NREAD    = 2;
   // Widest data width the zero helper covers; callers cast down to XLEN.
   localparam int unsigned RF_MAX_XLEN = 64;

   function automatic logic [RF_MAX_XLEN-1:0] rf_zero();
      return '0;
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Zero-clear sequencer: walks every register address once after reset or on
// request, then raises ready. Owns the CLEAR/RUN state machine.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int unsigned NREGS = RF_NREGS,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          clear_req,
   output logic          ready,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   rf_state_e     state_q, state_d;
   logic [AW-1:0] clr_cnt_q, clr_cnt_d;
   logic          ready_q, ready_d;

   // Next-state: step the clear counter in CLEAR, accept clear_req only in RUN.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         RF_CLEAR: begin
            clr_cnt_d = clr_cnt_q + AW'(1);
            if (clr_cnt_q == AW'(NREGS - 1)) begin
               state_d = RF_RUN;
            end
         end
         RF_RUN: begin
            if (clear_req) begin
               state_d   = RF_CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: begin
            state_d   = RF_CLEAR;
            clr_cnt_d = '0;
         end
      endcase
      ready_d = (state_d == RF_RUN);
   end

   // State register; reset always restarts the clear walk from address 0.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= RF_CLEAR;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         ready_q   <= ready_d;
      end
   end

   assign ready    = ready_q;
   assign clr_we   = (state_q == RF_CLEAR);
   assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with registered reads and a built-in
// zero-clear sequencer. Optional write-through bypass: define REGFILE_BYPASS_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned  XLEN     = RF_XLEN,
   parameter int unsigned  NREGS    = RF_NREGS,
   parameter int unsigned  NREAD    = RF_NREAD,
   parameter int unsigned  ZERO_REG = 1,
   localparam int unsigned AW       = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clear_req,
   output logic                  ready,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [XLEN-1:0]       wdata,
   input  logic [NREAD*AW-1:0]   raddr,
   output logic [NREAD*XLEN-1:0] rdata
);

   localparam logic [XLEN-1:0] Zero = XLEN'(rf_zero());

   logic [XLEN-1:0] mem_q [NREGS];

   logic            clr_we;
   logic [AW-1:0]   clr_addr;
   logic            user_wr;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;

   regfile_clear_seq #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_clear_seq (
      .clk       (clk),
      .resetn    (resetn),
      .clear_req (clear_req),
      .ready     (ready),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr)
   );

   // Write mux: the clear walk owns the port in CLEAR; user writes are dropped
   // alongside clear_req and when targeting a hardwired zero register.
   always_comb begin
      user_wr = ready && we && !clear_req && !((ZERO_REG != 0) && (waddr == '0));
      wr_en   = 1'b0;
      wr_addr = waddr;
      wr_data = wdata;
      if (clr_we) begin
         wr_en   = 1'b1;
         wr_addr = clr_addr;
         wr_data = Zero;
      end else if (user_wr) begin
         wr_en = 1'b1;
      end
   end

   // Storage is deliberately unreset; the clear walk zeroes it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd_d, rd_q;

      assign ra = raddr[i*AW +: AW];

      // Read select: CLEAR and the zero register win over storage and bypass.
      always_comb begin
         rd_d = mem_q[ra];
         if (!ready) begin
            rd_d = Zero;
         end else if ((ZERO_REG != 0) && (ra == '0)) begin
            rd_d = Zero;
`ifdef REGFILE_BYPASS_EN
         end else if (user_wr && (waddr == ra)) begin
            rd_d = wdata;
`endif
         end
      end

      // Registered read data, cleared asynchronously with the file.
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            rd_q <= Zero;
         end else begin
            rd_q <= rd_d;
         end
      end

      assign rdata[i*XLEN +: XLEN] = rd_q;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a ZERO_REG=1 and a ZERO_REG=0 instance share
// all inputs; expected values are hand-computed constants.
module tb_regfile_mp;

   logic        clk;
   logic        resetn;
   logic        clear_req;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [9:0]  raddr;
   logic        ready, ready_z0;
   logic [63:0] rdata, rdata_z0;

   int checks = 0;
   int errors = 0;

`ifdef REGFILE_BYPASS_EN
   localparam logic [31:0] SameCycleExp = 32'hA5A5_A5A5;
`else
   localparam logic [31:0] SameCycleExp = 32'h0000_0011;
`endif

   regfile_mp #(
      .XLEN     (32),
      .NREGS    (32),
      .NREAD    (2),
      .ZERO_REG (1)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .clear_req (clear_req),
      .ready     (ready),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .raddr     (raddr),
      .rdata     (rdata)
   );

   regfile_mp #(
      .XLEN     (32),
      .NREGS    (32),
      .NREAD    (2),
      .ZERO_REG (0)
   ) dut_z0 (
      .clk       (clk),
      .resetn    (resetn),
      .clear_req (clear_req),
      .ready     (ready_z0),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .raddr     (raddr),
      .rdata     (rdata_z0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_raddr(input int p1, input int p0);
      raddr = {5'(p1), 5'(p0)};
   endtask

   initial begin
      resetn    = 1'b0;
      clear_req = 1'b0;
      we        = 1'b0;
      waddr     = '0;
      wdata     = '0;
      raddr     = '0;
      repeat (2) tick();
      chk("reset_ready", 64'(ready), 64'd0);
      chk("reset_rdata", rdata, 64'd0);

      // Initial clear: ready low for exactly 32 cycles.
      resetn = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         tick();
         chk($sformatf("init_ready_%0d", k), 64'(ready), 64'(k == 32));
         chk($sformatf("init_rdata_%0d", k), rdata, 64'd0);
      end

      // Every register reads zero after the clear.
      for (int a = 0; a < 32; a++) begin
         set_raddr(a, a);
         tick();
         chk($sformatf("init_rd_%0d", a), rdata, 64'd0);
         chk($sformatf("init_rd_z0_%0d", a), rdata_z0, 64'd0);
      end

      // Write x5, read on both ports.
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
      tick();
      we = 1'b0; set_raddr(5, 5);
      tick();
      chk("x5_both_ports", rdata, {32'hDEAD_BEEF, 32'hDEAD_BEEF});

      // Write to x0: hardwired zero vs ordinary storage.
      we = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234;
      tick();
      we = 1'b0; set_raddr(0, 0);
      tick();
      chk("x0_zero_reg", 64'(rdata[31:0]), 64'h0);
      chk("x0_plain_reg", 64'(rdata_z0[31:0]), 64'h1234);

      // Same-cycle write and read of x7.
      we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0011;
      tick();
      wdata = 32'hA5A5_A5A5; set_raddr(0, 7);
      tick();
      we = 1'b0;
      chk("x7_same_cycle", 64'(rdata[31:0]), 64'(SameCycleExp));
      tick();
      chk("x7_next_cycle", 64'(rdata[31:0]), 64'h0000_0000_A5A5_A5A5);

      // Fill x1..x31, spot-check two entries.
      for (int i = 1; i < 32; i++) begin
         we = 1'b1; waddr = 5'(i); wdata = 32'h1000_0000 | 32'(i);
         tick();
      end
      we = 1'b0; set_raddr(31, 3);
      tick();
      chk("fill_readback", rdata, {32'h1000_001F, 32'h1000_0003});

      // clear_req with a colliding write: write dropped, no bypass of it.
      clear_req = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h77;
      tick();
      clear_req = 1'b0; we = 1'b0;
      chk("clr_req_ready", 64'(ready), 64'd0);
      chk("clr_req_drop_rd", 64'(rdata[31:0]), 64'h1000_0003);
      for (int k = 1; k <= 32; k++) begin
         tick();
         chk($sformatf("clr_ready_%0d", k), 64'(ready), 64'(k == 32));
      end
      for (int a = 0; a < 32; a++) begin
         set_raddr(a, a);
         tick();
         chk($sformatf("clr_rd_%0d", a), rdata, 64'd0);
         chk($sformatf("clr_rd_z0_%0d", a), rdata_z0, 64'd0);
      end

      // Asynchronous reset during RUN with nonzero read data.
      we = 1'b1; waddr = 5'd9; wdata = 32'h99;
      tick();
      we = 1'b0; set_raddr(9, 9);
      tick();
      chk("x9_before_rst", rdata, {32'h99, 32'h99});
      #2 resetn = 1'b0;
      #1;
      chk("run_rst_ready", 64'(ready), 64'd0);
      chk("run_rst_rdata", rdata, 64'd0);
      tick();
      resetn = 1'b1;

      // Reset again at cycle 10 of the clear walk.
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("mid_ready_%0d", k), 64'(ready), 64'd0);
      end
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(ready), 64'd0);
      chk("mid_rst_rdata", rdata, 64'd0);
      tick();
      resetn = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         tick();
         chk($sformatf("restart_ready_%0d", k), 64'(ready), 64'(k == 32));
      end
      tick();
      chk("x9_after_clear", rdata, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
